// File: rtl/player_lives_mgr.sv
// Per-player lives, respawn delay and post-respawn shield for the VGA game.
// Define LIVES_BONUS_EN to honour the bonus input; otherwise bonus is ignored.
module player_lives_mgr #(
    parameter int NUM_PLAYERS    = 2,
    parameter int LIVES_W        = 3,
    parameter int START_LIVES    = 3,
    parameter int MAX_LIVES      = 7,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SHIELD_FRAMES  = 120
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_tick,
    input  logic                           new_game,
    input  logic                           force_over,
    input  logic [NUM_PLAYERS-1:0]         hit,
    input  logic [NUM_PLAYERS-1:0]         bonus,
    output logic [NUM_PLAYERS*LIVES_W-1:0] lives_left,
    output logic [NUM_PLAYERS-1:0]         visible,
    output logic [NUM_PLAYERS-1:0]         invuln,
    output logic [NUM_PLAYERS-1:0]         life_lost,
    output logic                           game_over
);

    localparam logic [1:0] ST_PLAYING = 2'd0;
    localparam logic [1:0] ST_RESPAWN = 2'd1;
    localparam logic [1:0] ST_SHIELD  = 2'd2;
    localparam logic [1:0] ST_OUT     = 2'd3;

    localparam int TMR_MAX = (RESPAWN_FRAMES > SHIELD_FRAMES) ? RESPAWN_FRAMES : SHIELD_FRAMES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [LIVES_W-1:0] START_L  = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] CAP_L    = LIVES_W'(MAX_LIVES);
    localparam logic [TMR_W-1:0]   RESP_T   = TMR_W'(RESPAWN_FRAMES);
    localparam logic [TMR_W-1:0]   SHIELD_T = TMR_W'(SHIELD_FRAMES);
    localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);

    logic [1:0]         state_q [NUM_PLAYERS];
    logic [1:0]         state_d [NUM_PLAYERS];
    logic [LIVES_W-1:0] lives_q [NUM_PLAYERS];
    logic [LIVES_W-1:0] lives_d [NUM_PLAYERS];
    logic [TMR_W-1:0]   timer_q [NUM_PLAYERS];
    logic [TMR_W-1:0]   timer_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] lost_q;
    logic [NUM_PLAYERS-1:0] lost_d;
    logic [NUM_PLAYERS-1:0] bonus_en;

`ifdef LIVES_BONUS_EN
    assign bonus_en = bonus;
`else
    logic unused_bonus;
    assign bonus_en     = '0;
    assign unused_bonus = ^bonus;
`endif

    function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] l);
        return (l >= CAP_L) ? CAP_L : l + 1'b1;
    endfunction

    always_comb begin
        lost_d = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            state_d[i] = state_q[i];
            lives_d[i] = lives_q[i];
            timer_d[i] = timer_q[i];
            if (new_game) begin
                state_d[i] = ST_PLAYING;
                lives_d[i] = START_L;
                timer_d[i] = '0;
            end else if (force_over) begin
                state_d[i] = ST_OUT;
                lives_d[i] = '0;
                timer_d[i] = '0;
            end else begin
                // Bonus applies first; a simultaneous hit then undoes it, so the net change is 0.
                if (bonus_en[i] && state_q[i] != ST_OUT) begin
                    lives_d[i] = sat_inc(lives_q[i]);
                end
                case (state_q[i])
                    ST_PLAYING: begin
                        if (hit[i]) begin
                            lost_d[i] = 1'b1;
                            if (bonus_en[i]) begin
                                lives_d[i] = lives_q[i];
                                state_d[i] = ST_RESPAWN;
                                timer_d[i] = RESP_T;
                            end else if (lives_q[i] <= LIVES_W'(1)) begin
                                lives_d[i] = '0;
                                state_d[i] = ST_OUT;
                                timer_d[i] = '0;
                            end else begin
                                lives_d[i] = lives_q[i] - 1'b1;
                                state_d[i] = ST_RESPAWN;
                                timer_d[i] = RESP_T;
                            end
                        end
                    end
                    ST_RESPAWN: begin
                        if (frame_tick) begin
                            if (timer_q[i] <= TMR_ONE) begin
                                state_d[i] = ST_SHIELD;
                                timer_d[i] = SHIELD_T;
                            end else begin
                                timer_d[i] = timer_q[i] - 1'b1;
                            end
                        end
                    end
                    ST_SHIELD: begin
                        if (frame_tick) begin
                            if (timer_q[i] <= TMR_ONE) begin
                                state_d[i] = ST_PLAYING;
                                timer_d[i] = '0;
                            end else begin
                                timer_d[i] = timer_q[i] - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_OUT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                state_q[i] <= ST_PLAYING;
                lives_q[i] <= START_L;
                timer_q[i] <= '0;
            end
            lost_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                state_q[i] <= state_d[i];
                lives_q[i] <= lives_d[i];
                timer_q[i] <= timer_d[i];
            end
            lost_q <= lost_d;
        end
    end

    // All outputs are decoded from registered state only.
    always_comb begin
        lives_left = '0;
        visible    = '0;
        invuln     = '0;
        game_over  = 1'b1;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            lives_left[i*LIVES_W +: LIVES_W] = lives_q[i];
            visible[i] = (state_q[i] == ST_PLAYING) || (state_q[i] == ST_SHIELD);
            invuln[i]  = (state_q[i] == ST_RESPAWN) || (state_q[i] == ST_SHIELD);
            if (state_q[i] != ST_OUT) begin
                game_over = 1'b0;
            end
        end
    end

    assign life_lost = lost_q;

endmodule

// File: tb/tb_player_lives_mgr.sv
// Directed bench for player_lives_mgr with default parameters (2 players, 3 lives).
// Expectations adapt when LIVES_BONUS_EN is defined.
module tb_player_lives_mgr;

`ifdef LIVES_BONUS_EN
    localparam bit BEN = 1'b1;
`else
    localparam bit BEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       new_game = 1'b0;
    logic       force_over = 1'b0;
    logic [1:0] hit = '0;
    logic [1:0] bonus = '0;
    logic [5:0] lives_left;
    logic [1:0] visible;
    logic [1:0] invuln;
    logic [1:0] life_lost;
    logic       game_over;

    int tests = 0;
    int fails = 0;

    player_lives_mgr dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .new_game(new_game),
        .force_over(force_over), .hit(hit), .bonus(bonus), .lives_left(lives_left),
        .visible(visible), .invuln(invuln), .life_lost(life_lost), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [1:0] h;
        logic [1:0] b;
        logic       t;
        logic       ng;
        logic       fo;
        logic [5:0] lv;
        logic [1:0] vis;
        logic [1:0] inv;
        logic [1:0] lost;
        logic       go;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input string nm, input logic [1:0] h, input logic [1:0] b,
                                input logic t, input logic ng, input logic fo,
                                input logic [5:0] lv, input logic [1:0] vis,
                                input logic [1:0] inv, input logic [1:0] lost, input logic go);
        vec_t v;
        v.nm = nm; v.h = h; v.b = b; v.t = t; v.ng = ng; v.fo = fo;
        v.lv = lv; v.vis = vis; v.inv = inv; v.lost = lost; v.go = go;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] h, input logic [1:0] b, input logic t,
                         input logic ng, input logic fo);
        hit = h; bonus = b; frame_tick = t; new_game = ng; force_over = fo;
        @(posedge clk);
        #1;
        hit = '0; bonus = '0; frame_tick = 1'b0; new_game = 1'b0; force_over = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_all(input string nm, input logic [5:0] lv, input logic [1:0] vis,
                           input logic [1:0] inv, input logic [1:0] lost, input logic go);
        chk({nm, ".lives"}, 32'(lives_left), 32'(lv));
        chk({nm, ".visible"}, 32'(visible), 32'(vis));
        chk({nm, ".invuln"}, 32'(invuln), 32'(inv));
        chk({nm, ".life_lost"}, 32'(life_lost), 32'(lost));
        chk({nm, ".game_over"}, 32'(game_over), 32'(go));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk("idle",       2'b00, 2'b00, 0, 0, 0, 6'b011_011, 2'b11, 2'b00, 2'b00, 0);
        vecs[1]  = mk("hit_p0",     2'b01, 2'b00, 0, 0, 0, 6'b011_010, 2'b10, 2'b01, 2'b01, 0);
        vecs[2]  = mk("hit_p0_rsp", 2'b01, 2'b00, 0, 0, 0, 6'b011_010, 2'b10, 2'b01, 2'b00, 0);
        vecs[3]  = mk("tick",       2'b00, 2'b00, 1, 0, 0, 6'b011_010, 2'b10, 2'b01, 2'b00, 0);
        vecs[4]  = mk("bonus_p1",   2'b00, 2'b10, 0, 0, 0, BEN ? 6'b100_010 : 6'b011_010,
                      2'b10, 2'b01, 2'b00, 0);
        vecs[5]  = mk("hit_p1",     2'b10, 2'b00, 0, 0, 0, BEN ? 6'b011_010 : 6'b010_010,
                      2'b00, 2'b11, 2'b10, 0);
        vecs[6]  = mk("ng_fo",      2'b00, 2'b00, 0, 1, 1, 6'b011_011, 2'b11, 2'b00, 2'b00, 0);
        vecs[7]  = mk("fo",         2'b00, 2'b00, 0, 0, 1, 6'b000_000, 2'b00, 2'b00, 2'b00, 1);
        vecs[8]  = mk("hit_out",    2'b11, 2'b00, 1, 0, 0, 6'b000_000, 2'b00, 2'b00, 2'b00, 1);
        vecs[9]  = mk("bonus_out",  2'b00, 2'b11, 0, 0, 0, 6'b000_000, 2'b00, 2'b00, 2'b00, 1);
        vecs[10] = mk("ng",         2'b00, 2'b00, 0, 1, 0, 6'b011_011, 2'b11, 2'b00, 2'b00, 0);
        vecs[11] = mk("ng_hit",     2'b11, 2'b00, 0, 1, 0, 6'b011_011, 2'b11, 2'b00, 2'b00, 0);
        vecs[12] = mk("fo_hit",     2'b11, 2'b11, 0, 0, 1, 6'b000_000, 2'b00, 2'b00, 2'b00, 1);
        vecs[13] = mk("ng2",        2'b00, 2'b00, 0, 1, 0, 6'b011_011, 2'b11, 2'b00, 2'b00, 0);

        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("reset", 6'b011_011, 2'b11, 2'b00, 2'b00, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].h, vecs[i].b, vecs[i].t, vecs[i].ng, vecs[i].fo);
            chk_all(vecs[i].nm, vecs[i].lv, vecs[i].vis, vecs[i].inv, vecs[i].lost, vecs[i].go);
        end

        // Respawn/shield durations; the tick on the hit cycle must not count.
        drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("tmr.hit_lives", 32'(lives_left[2:0]), 32'd2);
        ticks(59);
        chk("tmr.rsp59_vis", 32'(visible[0]), 32'd0);
        chk("tmr.rsp59_inv", 32'(invuln[0]), 32'd1);
        ticks(1);
        chk("tmr.shield_vis", 32'(visible[0]), 32'd1);
        chk("tmr.shield_inv", 32'(invuln[0]), 32'd1);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("tmr.shield_hit_lives", 32'(lives_left[2:0]), 32'd2);
        chk("tmr.shield_hit_lost", 32'(life_lost), 32'd0);
        for (int k = 0; k < 119; k++) begin
            drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
            drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        chk("tmr.sh119_inv", 32'(invuln[0]), 32'd1);
        ticks(1);
        chk("tmr.play_inv", 32'(invuln[0]), 32'd0);
        chk("tmr.play_vis", 32'(visible[0]), 32'd1);
        chk("tmr.play_lives", 32'(lives_left), 32'(6'b011_010));

        // Game over only once both players are out.
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
            ticks(180);
        end
        chk("go.p1_one", 32'(lives_left), 32'(6'b001_011));
        drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_all("go.p1_out", 6'b000_011, 2'b01, 2'b00, 2'b10, 1'b0);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("go.lost_clear", 32'(life_lost), 32'd0);
        for (int r = 0; r < 2; r++) begin
            drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
            ticks(180);
        end
        chk("go.p0_one_go", 32'(game_over), 32'd0);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_all("go.both_out", 6'b000_000, 2'b00, 2'b00, 2'b01, 1'b1);

        // Bonus saturation and hit+bonus interaction.
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("bn.sat", 32'(lives_left[2:0]), BEN ? 32'd7 : 32'd3);
        drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("bn.hitmax_lives", 32'(lives_left[2:0]), BEN ? 32'd7 : 32'd2);
        chk("bn.hitmax_lost", 32'(life_lost), 32'd1);
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
            ticks(180);
        end
        drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("bn.hit1_lives", 32'(lives_left[2:0]), BEN ? 32'd1 : 32'd0);
        chk("bn.hit1_inv", 32'(invuln[0]), BEN ? 32'd1 : 32'd0);
        chk("bn.hit1_vis", 32'(visible[0]), 32'd0);
        chk("bn.hit1_lost", 32'(life_lost), 32'd1);

        // Asynchronous reset mid-RESPAWN, then a clean 60-tick respawn.
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        ticks(10);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.mid", 6'b011_011, 2'b11, 2'b00, 2'b00, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("rst.after", 6'b011_011, 2'b11, 2'b00, 2'b00, 1'b0);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        ticks(59);
        chk("rst.rsp59_vis", 32'(visible[0]), 32'd0);
        ticks(1);
        chk("rst.rsp60_vis", 32'(visible[0]), 32'd1);
        chk("rst.rsp60_inv", 32'(invuln[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
